// File: rtl/sig_pkg.sv
// rtl/sig_pkg.sv - shared widths and FSM state type for the sample path
//
// Purpose : default address/data widths shared with the sine generator, and
//           the fill/run state encoding used by sample_delay_buf.
// Ports   : none (package).
package sig_pkg;

    localparam int A_WIDTH = 8;
    localparam int D_WIDTH = 8;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Output source selection, held between strobes so dout stays stable.
    typedef enum logic [1:0] {
        SEL_MUTE = 2'd0,
        SEL_BYP  = 2'd1,
        SEL_RAM  = 2'd2
    } out_sel_t;

endpackage

// File: rtl/ram2port.sv
// rtl/ram2port.sv - simple dual-port RAM with registered read data
//
// Purpose : 2**A_WIDTH x D_WIDTH sample store, one write and one read port.
// Ports   : clk            - clock
//           we/waddr/wdata - write port
//           re/raddr       - read enable and address
//           rdata          - read data, registered; holds while re=0
module ram2port
    import sig_pkg::*;
#(
    parameter int AW = A_WIDTH,
    parameter int DW = D_WIDTH
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sample_delay_buf.sv
// rtl/sample_delay_buf.sv - programmable sample delay line over a circular RAM
//
// Purpose : writes each strobed sample into a circular RAM and plays it back
//           'delay' strobes later; delay=0 passes the sample straight through.
// Ports   : clk   - clock
//           rst   - synchronous active-high reset
//           en    - sample strobe
//           din   - input sample
//           delay - delay in strobes
//           dout  - delayed sample (0 while filling)
//           valid - dout holds a genuine delayed sample
module sample_delay_buf
    import sig_pkg::*;
#(
    parameter int A_WIDTH = sig_pkg::A_WIDTH,
    parameter int D_WIDTH = sig_pkg::D_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] din,
    input  logic [A_WIDTH-1:0] delay,
    output logic [D_WIDTH-1:0] dout,
    output logic               valid
);

    logic [A_WIDTH-1:0] wr_ptr_q;
    logic [A_WIDTH-1:0] fill_cnt_q;
    logic [A_WIDTH-1:0] delay_q;
    state_t             state_q;
    out_sel_t           sel_q;
    logic [D_WIDTH-1:0] byp_q;
    logic               valid_q;
    logic [A_WIDTH-1:0] rd_addr_d;
    logic [D_WIDTH-1:0] rdata;
    logic               delay_chg_d;

    // Modular subtract: wraps naturally at A_WIDTH bits.
    assign rd_addr_d   = wr_ptr_q - delay;
    assign delay_chg_d = (delay != delay_q);

    // Read only on strobes so rdata, and therefore dout, holds between them.
    ram2port #(
        .AW(A_WIDTH),
        .DW(D_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (en),
        .waddr(wr_ptr_q),
        .wdata(din),
        .re   (en),
        .raddr(rd_addr_d),
        .rdata(rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            delay_q    <= '0;
            state_q    <= FILL;
            sel_q      <= SEL_MUTE;
            byp_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            delay_q <= delay;
            if (en) begin
                wr_ptr_q <= wr_ptr_q + A_WIDTH'(1);
            end
            // A delay change wins over a coincident strobe: the sample is
            // still written, but it does not count toward the refill.
            if (delay_chg_d) begin
                state_q    <= FILL;
                fill_cnt_q <= '0;
                sel_q      <= SEL_MUTE;
                valid_q    <= 1'b0;
            end else if (en) begin
                if (state_q == RUN || fill_cnt_q == delay) begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                    sel_q   <= (delay == '0) ? SEL_BYP : SEL_RAM;
                    byp_q   <= din;
                end else begin
                    fill_cnt_q <= fill_cnt_q + A_WIDTH'(1);
                    sel_q      <= SEL_MUTE;
                    valid_q    <= 1'b0;
                end
            end
        end
    end

    // Both sources are already registered one cycle after the strobe, so
    // this mux only aligns them; it adds no latency.
    always_comb begin
        dout = '0;
        unique case (sel_q)
            SEL_BYP:  dout = byp_q;
            SEL_RAM:  dout = rdata;
            default:  dout = '0;
        endcase
    end

    assign valid = valid_q;

endmodule

// File: tb/tb_sample_delay_buf.sv
// tb/tb_sample_delay_buf.sv - directed self-checking bench for sample_delay_buf
module tb_sample_delay_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [7:0] din = 8'd0;
    logic [7:0] delay = 8'd0;
    logic [7:0] dout;
    logic       valid;

    int checks = 0;
    int errors = 0;

    sample_delay_buf dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (din),
        .delay(delay),
        .dout (dout),
        .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic e, input logic [7:0] d);
        @(negedge clk);
        en  = e;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp_dout, input logic exp_valid);
        checks++;
        assert (dout === exp_dout) else begin
            errors++;
            $error("FAIL %s dout: observed %0d expected %0d", tag, dout, exp_dout);
        end
        checks++;
        assert (valid === exp_valid) else begin
            errors++;
            $error("FAIL %s valid: observed %0d expected %0d", tag, valid, exp_valid);
        end
    endtask

    task automatic do_reset(input logic [7:0] dl);
        @(negedge clk);
        rst   = 1'b1;
        en    = 1'b0;
        delay = dl;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Bypass, delay 0
        do_reset(8'd0);
        cyc(1'b1, 8'd10); check("byp0", 8'd10, 1'b1);
        cyc(1'b1, 8'd11); check("byp1", 8'd11, 1'b1);
        cyc(1'b1, 8'd12); check("byp2", 8'd12, 1'b1);
        cyc(1'b0, 8'd99); check("byp_hold", 8'd12, 1'b1);

        // Fixed delay 3; first idle cycle absorbs the post-reset delay change
        do_reset(8'd3);
        cyc(1'b0, 8'd0); check("d3_idle", 8'd0, 1'b0);
        cyc(1'b1, 8'd0); check("d3_s0", 8'd0, 1'b0);
        cyc(1'b1, 8'd1); check("d3_s1", 8'd0, 1'b0);
        cyc(1'b1, 8'd2); check("d3_s2", 8'd0, 1'b0);
        cyc(1'b1, 8'd3); check("d3_s3", 8'd0, 1'b1);
        cyc(1'b1, 8'd4); check("d3_s4", 8'd1, 1'b1);
        cyc(1'b1, 8'd5); check("d3_s5", 8'd2, 1'b1);
        cyc(1'b0, 8'd77); check("d3_hold", 8'd2, 1'b1);

        // Gapped strobes, delay 2
        do_reset(8'd2);
        cyc(1'b0, 8'd0);
        cyc(1'b1, 8'd5); check("gap_s0", 8'd0, 1'b0);
        cyc(1'b0, 8'd0); cyc(1'b0, 8'd0); check("gap_h0", 8'd0, 1'b0);
        cyc(1'b1, 8'd6); check("gap_s1", 8'd0, 1'b0);
        cyc(1'b0, 8'd0); cyc(1'b0, 8'd0); check("gap_h1", 8'd0, 1'b0);
        cyc(1'b1, 8'd7); check("gap_s2", 8'd5, 1'b1);
        cyc(1'b0, 8'd0); check("gap_h2a", 8'd5, 1'b1);
        cyc(1'b0, 8'd0); check("gap_h2b", 8'd5, 1'b1);
        cyc(1'b1, 8'd8); check("gap_s3", 8'd6, 1'b1);

        // Wraparound, delay 5, 300 continuous strobes
        do_reset(8'd5);
        cyc(1'b0, 8'd0);
        for (int n = 0; n < 300; n++) begin
            cyc(1'b1, 8'(n));
            if (n < 5) check("wrap_fill", 8'd0, 1'b0);
            else       check("wrap_run", 8'(n - 5), 1'b1);
            if (n == 260) check("wrap_260", 8'd255, 1'b1);
        end

        // Delay change 4 -> 2 in RUN
        do_reset(8'd4);
        cyc(1'b0, 8'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 8'(100 + k)); check("chg_fill4", 8'd0, 1'b0);
        end
        cyc(1'b1, 8'd104); check("chg_run0", 8'd100, 1'b1);
        cyc(1'b1, 8'd105); check("chg_run1", 8'd101, 1'b1);
        cyc(1'b1, 8'd106); check("chg_run2", 8'd102, 1'b1);
        @(negedge clk);
        delay = 8'd2;
        en    = 1'b1;
        din   = 8'd107;
        @(posedge clk);
        #1;
        check("chg_drop", 8'd0, 1'b0);
        cyc(1'b1, 8'd108); check("chg_refill0", 8'd0, 1'b0);
        cyc(1'b1, 8'd109); check("chg_refill1", 8'd0, 1'b0);
        cyc(1'b1, 8'd110); check("chg_valid", 8'd108, 1'b1);
        cyc(1'b1, 8'd111); check("chg_next", 8'd109, 1'b1);

        // Reset mid-run with strobes active, then check address 0 is written first
        @(negedge clk);
        rst   = 1'b1;
        delay = 8'd1;
        din   = 8'd55;
        @(posedge clk); #1;
        check("rst_mid1", 8'd0, 1'b0);
        @(posedge clk); #1;
        check("rst_mid2", 8'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        cyc(1'b0, 8'd0); check("rst_idle", 8'd0, 1'b0);
        cyc(1'b1, 8'd200); check("rst_s0", 8'd0, 1'b0);
        cyc(1'b1, 8'd201); check("rst_s1_addr0", 8'd200, 1'b1);
        cyc(1'b1, 8'd202); check("rst_s2", 8'd201, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
